// File: rtl/booth_divider_if.sv
// Handshake and result bundle for the sequential signed divider.
// The bench drives the master side; the divider implements the slave side.
interface booth_divider_if #(
  parameter int unsigned Width_divisor  = 16,
  parameter int unsigned Width_dividend = 32
);
  logic [Width_dividend-1:0] in_dividend;
  logic [Width_divisor-1:0]  in_divisor;
  logic                      ld;
  logic                      busy;
  logic                      done;
  logic [Width_divisor-1:0]  quotient;
  logic [Width_divisor-1:0]  remainder;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output in_dividend, in_divisor, ld,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_dividend, in_divisor, ld,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/booth_divider.sv
// Sequential signed 2N/N divider: restoring radix-2 on magnitudes, then sign correction.
// One quotient bit per cycle; early exit on divide-by-zero or guaranteed quotient overflow.
module booth_divider #(
  parameter int unsigned Width_divisor  = 16,
  parameter int unsigned Width_dividend = 32
) (
  input logic            clk,
  input logic            reset,
  booth_divider_if.slave bus
);
  localparam int unsigned N    = Width_divisor;
  localparam int unsigned M    = Width_dividend;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    low_q, low_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic            q_sign_q, q_sign_d;
  logic            r_sign_q, r_sign_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    remo_q, remo_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [M-1:0]    dvd_abs;
  logic [N-1:0]    dvs_abs;
  logic [N:0]      shifted;
  logic            trial_ge;
  logic [N-1:0]    trial;
  logic            range_ovf;

  // -2^(M-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign dvd_abs  = bus.in_dividend[M-1] ? -bus.in_dividend : bus.in_dividend;
  assign dvs_abs  = bus.in_divisor[N-1] ? -bus.in_divisor : bus.in_divisor;

  // rem < |dvs| holds throughout, so a non-negative trial always fits in N bits.
  assign shifted  = {rem_q, low_q[N-1]};
  assign trial_ge = shifted >= {1'b0, dvs_q};
  assign trial    = shifted[N-1:0] - dvs_q;

  assign range_ovf = q_sign_q ? (low_q[N-1] && (|low_q[N-2:0])) : low_q[N-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    low_d    = low_q;
    dvs_d    = dvs_q;
    q_sign_d = q_sign_q;
    r_sign_d = r_sign_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The done cycle still belongs to the previous divide, so ld is not taken there.
        if (bus.ld && !done_q) begin
          rem_d    = dvd_abs[M-1:N];
          low_d    = dvd_abs[N-1:0];
          dvs_d    = dvs_abs;
          q_sign_d = bus.in_dividend[M-1] ^ bus.in_divisor[N-1];
          r_sign_d = bus.in_dividend[M-1];
          cnt_d    = '0;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
          if (bus.in_divisor == '0) begin
            dbz_d   = 1'b1;
            low_d   = bus.in_dividend[N-1:0];
            state_d = StFinish;
          end else if (dvd_abs[M-1:N] >= dvs_abs) begin
            ovf_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (trial_ge) begin
          rem_d = trial;
          low_d = {low_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          low_d = {low_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (dbz_q) begin
          quot_d = '1;
          remo_d = low_q;
        end else if (ovf_q || range_ovf) begin
          ovf_d  = 1'b1;
          quot_d = {1'b1, {(N-1){1'b0}}};
          remo_d = '0;
        end else begin
          quot_d = q_sign_q ? -low_q : low_q;
          remo_d = r_sign_q ? -rem_q : rem_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      low_q    <= '0;
      dvs_q    <= '0;
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      quot_q   <= '0;
      remo_q   <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      low_q    <= low_d;
      dvs_q    <= dvs_d;
      q_sign_q <= q_sign_d;
      r_sign_q <= r_sign_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q == StCalc) || (state_q == StFinish);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule
